instr_fetch_seq: RTL and testbench
==================================

INSTR_FETCH_SEQ -- requirements
Module: instr_fetch_seq

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 start  input  1  fetch request, sampled on the rising clk edge.
REQ-005 src  input  2  first source port index for the fetch, sampled with start.
REQ-006 data_in  input  8  byte from the downstream 4:1 data mux output; combinational in the same cycle as sel.
REQ-007 ack  input  1  consumer accepts the completed instruction.
REQ-008 sel  output  2  registered select driven to the data mux.
REQ-009 opcode  output  8  registered first instruction byte.
REQ-010 operand  output  16  registered operand bytes; byte1 in [7:0], byte2 in [15:8].
REQ-011 len  output  2  registered instruction length in bytes (1..3).
REQ-012 valid  output  1  instruction complete and outputs stable.
REQ-013 busy  output  1  high in any fetch state.

Function
REQ-014 The FSM SHALL have the states IDLE, F_OP, F_B1, F_B2 and DONE; busy SHALL be 1 exactly in F_OP, F_B1 and F_B2, and valid SHALL be 1 exactly in DONE.
REQ-015 In IDLE with start=1 at an edge, the block SHALL load sel<=src, clear operand to 0, and go to F_OP; with start=0 it SHALL stay in IDLE.
REQ-016 In F_OP, at the edge the block SHALL capture opcode<=data_in and decode the length as follows.
- opcode[7:6]=00 -> length 1.
- opcode[7:6]=01 -> length 2.
- opcode[7:6]=1x -> length 3.
- It SHALL write len with that length.
REQ-017 After F_OP, a length-1 instruction SHALL go to DONE; otherwise the block SHALL set sel<=sel+1 and go to F_B1.
REQ-018 In F_B1, at the edge the block SHALL capture operand[7:0]<=data_in.
- A length-2 instruction SHALL then go to DONE.
- A length-3 instruction SHALL set sel<=sel+1 and go to F_B2.
REQ-019 In F_B2, at the edge the block SHALL capture operand[15:8]<=data_in and go to DONE.
REQ-020 sel increment SHALL be modulo 4, so 3 wraps to 0.
REQ-021 On every entry to DONE, sel SHALL be set to 0.
REQ-022 Latency from the start edge to valid high SHALL be 2, 3 or 4 edges for length 1, 2 or 3 respectively.
REQ-023 In DONE, valid, opcode, operand and len SHALL hold until ack=1 is sampled.
REQ-024 In DONE with ack=1 and start=0, the block SHALL go to IDLE.
REQ-025 In DONE with ack=1 and start=1, the block SHALL go directly to F_OP with sel<=src and operand cleared (back-to-back fetch).
REQ-026 start SHALL be ignored in F_OP, F_B1 and F_B2, and in DONE when ack=0.
REQ-027 ack SHALL be ignored outside DONE.
REQ-028 opcode and len SHALL retain their last values in IDLE; only a new F_OP capture changes them.

Reset
REQ-029 rst=1 SHALL immediately, without waiting for clk, force the following values.
- state IDLE.
- sel=0, opcode=0, operand=0, len=0.
- valid=0, busy=0.
REQ-030 Reset asserted during any fetch state SHALL abort the fetch; after release, the first start SHALL behave as from IDLE.

Verification
Mux ports for all scenarios: in0=AA, in1=55, in2=23, in3=78.
REQ-031 Scenario 1: start, src=2 -> sel=2, then valid after 2 edges with opcode=23, len=1, operand=0000.
REQ-032 Scenario 2: start, src=1 -> sel sequence 1,2, then valid after 3 edges with opcode=55, len=2, operand=0023.
REQ-033 Scenario 3: start, src=0 -> sel sequence 0,1,2, then valid after 4 edges with opcode=AA, len=3, operand=2355.
REQ-034 Scenario 4: start, src=3 -> sel sequence 3,0 (wrap), then opcode=78, len=2, operand=00AA.
REQ-035 Scenario 5: hold ack=0 for 5 cycles in DONE with start=1 toggling -> valid and outputs stay stable; then ack=1 with start=1, src=2 -> busy on the next edge, then opcode=23, valid.
REQ-036 Scenario 6: assert rst mid-F_B1 of an src=0 fetch -> outputs are 0 immediately without a clock edge; after release, start with src=1 -> opcode=55, operand=0023.

Source files
------------

// File: rtl/instr_fetch_seq.sv
// -----------------------------------------------------------------------------
// instr_fetch_seq
//   Fetches a 1..3 byte instruction through an external 4:1 byte mux.
//   The opcode's top two bits give the length. Each further byte comes from
//   the next mux port, and the port index wraps modulo 4. The finished
//   instruction is held with valid=1 until the consumer acks it. Start
//   together with ack chains straight into the next fetch.
//
// Ports
//   clk      in   1   rising-edge clock
//   rst      in   1   asynchronous active-high reset
//   start    in   1   fetch request (IDLE, or DONE together with ack)
//   src      in   2   mux port holding the opcode byte
//   data_in  in   8   mux output, combinational from sel
//   ack      in   1   consumer accepts the completed instruction
//   sel      out  2   registered mux select
//   opcode   out  8   first instruction byte
//   operand  out 16   byte1 in [7:0], byte2 in [15:8]
//   len      out  2   instruction length in bytes (1..3)
//   valid    out  1   instruction complete (DONE)
//   busy     out  1   fetch in progress (F_OP/F_B1/F_B2)
// -----------------------------------------------------------------------------
module instr_fetch_seq #(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            src,
    input  logic [DATA_W-1:0]     data_in,
    input  logic                  ack,
    output logic [1:0]            sel,
    output logic [DATA_W-1:0]     opcode,
    output logic [2*DATA_W-1:0]   operand,
    output logic [1:0]            len,
    output logic                  valid,
    output logic                  busy
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        F_OP = 3'd1,
        F_B1 = 3'd2,
        F_B2 = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t state;

    // Length from opcode[7:6]: 00 -> 1, 01 -> 2, 1x -> 3.
    function automatic logic [1:0] decode_len(input logic [DATA_W-1:0] op);
        logic [1:0] l;
        case (op[DATA_W-1 -: 2])
            2'b00:   l = 2'd1;
            2'b01:   l = 2'd2;
            default: l = 2'd3;
        endcase
        return l;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            sel     <= 2'd0;
            opcode  <= '0;
            operand <= '0;
            len     <= 2'd0;
            valid   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sel     <= src;
                        operand <= '0;
                        busy    <= 1'b1;
                        state   <= F_OP;
                    end
                end

                F_OP: begin
                    opcode <= data_in;
                    len    <= decode_len(data_in);
                    if (decode_len(data_in) == 2'd1) begin
                        sel   <= 2'd0;
                        busy  <= 1'b0;
                        valid <= 1'b1;
                        state <= DONE;
                    end else begin
                        sel   <= sel + 2'd1;   // 2-bit add wraps 3 -> 0
                        state <= F_B1;
                    end
                end

                F_B1: begin
                    operand[DATA_W-1:0] <= data_in;
                    // len was written in F_OP and holds the decoded length.
                    if (len == 2'd2) begin
                        sel   <= 2'd0;
                        busy  <= 1'b0;
                        valid <= 1'b1;
                        state <= DONE;
                    end else begin
                        sel   <= sel + 2'd1;
                        state <= F_B2;
                    end
                end

                F_B2: begin
                    operand[2*DATA_W-1:DATA_W] <= data_in;
                    sel   <= 2'd0;
                    busy  <= 1'b0;
                    valid <= 1'b1;
                    state <= DONE;
                end

                DONE: begin
                    if (ack) begin
                        valid <= 1'b0;
                        if (start) begin
                            // Back-to-back: skip IDLE and fetch immediately.
                            sel     <= src;
                            operand <= '0;
                            busy    <= 1'b1;
                            state   <= F_OP;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    sel   <= 2'd0;
                    valid <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_seq.sv
module tb_instr_fetch_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start;
    logic [1:0]  src;
    logic [7:0]  data_in;
    logic        ack;
    logic [1:0]  sel;
    logic [7:0]  opcode;
    logic [15:0] operand;
    logic [1:0]  len;
    logic        valid;
    logic        busy;

    int total = 0;
    int bad   = 0;

    instr_fetch_seq dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .src     (src),
        .data_in (data_in),
        .ack     (ack),
        .sel     (sel),
        .opcode  (opcode),
        .operand (operand),
        .len     (len),
        .valid   (valid),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Downstream 4:1 mux: in0=AA, in1=55, in2=23, in3=78.
    always_comb begin
        case (sel)
            2'd0:    data_in = 8'hAA;
            2'd1:    data_in = 8'h55;
            2'd2:    data_in = 8'h23;
            2'd3:    data_in = 8'h78;
            default: data_in = 8'hXX;
        endcase
    end

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Status vector compared below: {busy, valid, sel}.
    // Data vector compared below:   {opcode, operand, len}.

    task automatic test_reset();
        start = 1'b0; src = 2'd0; ack = 1'b0;
        #1 rst = 1'b1;
        #2;
        total++;
        if ({busy, valid, sel} !== 4'b0000) begin
            bad++; $display("FAIL reset_status got=%b exp=%b", {busy, valid, sel}, 4'b0000);
        end
        total++;
        if ({opcode, operand, len} !== 26'h0) begin
            bad++; $display("FAIL reset_data got=%h exp=%h", {opcode, operand, len}, 26'h0);
        end
        step();
        rst = 1'b0;
        step();
        total++;
        if ({busy, valid, sel} !== 4'b0000) begin
            bad++; $display("FAIL idle_no_start got=%b exp=%b", {busy, valid, sel}, 4'b0000);
        end
    endtask

    task automatic test_len1();
        start = 1'b1; src = 2'd2;
        step();
        start = 1'b0;
        total++;
        if ({busy, valid, sel, operand} !== {1'b1, 1'b0, 2'd2, 16'h0000}) begin
            bad++; $display("FAIL len1_fop got=%h exp=%h", {busy, valid, sel, operand}, {1'b1, 1'b0, 2'd2, 16'h0000});
        end
        step();
        total++;
        if ({busy, valid, sel} !== 4'b0100) begin
            bad++; $display("FAIL len1_done_status got=%b exp=%b", {busy, valid, sel}, 4'b0100);
        end
        total++;
        if ({opcode, operand, len} !== {8'h23, 16'h0000, 2'd1}) begin
            bad++; $display("FAIL len1_done_data got=%h exp=%h", {opcode, operand, len}, {8'h23, 16'h0000, 2'd1});
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        total++;
        if ({busy, valid, opcode, len} !== {1'b0, 1'b0, 8'h23, 2'd1}) begin
            bad++; $display("FAIL len1_idle_retain got=%h exp=%h", {busy, valid, opcode, len}, {1'b0, 1'b0, 8'h23, 2'd1});
        end
    endtask

    // ack held high throughout the fetch: it must be ignored until DONE.
    task automatic test_len2();
        start = 1'b1; src = 2'd1; ack = 1'b1;
        step();
        start = 1'b0;
        total++;
        if ({busy, valid, sel} !== {1'b1, 1'b0, 2'd1}) begin
            bad++; $display("FAIL len2_fop got=%b exp=%b", {busy, valid, sel}, {1'b1, 1'b0, 2'd1});
        end
        step();
        total++;
        if ({busy, valid, sel, opcode, len} !== {1'b1, 1'b0, 2'd2, 8'h55, 2'd2}) begin
            bad++; $display("FAIL len2_fb1 got=%h exp=%h", {busy, valid, sel, opcode, len}, {1'b1, 1'b0, 2'd2, 8'h55, 2'd2});
        end
        step();
        total++;
        if ({busy, valid, sel} !== 4'b0100) begin
            bad++; $display("FAIL len2_done_status got=%b exp=%b", {busy, valid, sel}, 4'b0100);
        end
        total++;
        if ({opcode, operand, len} !== {8'h55, 16'h0023, 2'd2}) begin
            bad++; $display("FAIL len2_done_data got=%h exp=%h", {opcode, operand, len}, {8'h55, 16'h0023, 2'd2});
        end
        step();
        ack = 1'b0;
        total++;
        if ({busy, valid} !== 2'b00) begin
            bad++; $display("FAIL len2_ack_idle got=%b exp=%b", {busy, valid}, 2'b00);
        end
    endtask

    // start held high with a different src during the fetch: must be ignored.
    task automatic test_len3();
        start = 1'b1; src = 2'd0;
        step();
        src = 2'd3;
        total++;
        if ({busy, valid, sel} !== {1'b1, 1'b0, 2'd0}) begin
            bad++; $display("FAIL len3_fop got=%b exp=%b", {busy, valid, sel}, {1'b1, 1'b0, 2'd0});
        end
        step();
        total++;
        if ({busy, valid, sel, opcode, len} !== {1'b1, 1'b0, 2'd1, 8'hAA, 2'd3}) begin
            bad++; $display("FAIL len3_fb1 got=%h exp=%h", {busy, valid, sel, opcode, len}, {1'b1, 1'b0, 2'd1, 8'hAA, 2'd3});
        end
        step();
        total++;
        if ({busy, valid, sel, operand} !== {1'b1, 1'b0, 2'd2, 16'h0055}) begin
            bad++; $display("FAIL len3_fb2 got=%h exp=%h", {busy, valid, sel, operand}, {1'b1, 1'b0, 2'd2, 16'h0055});
        end
        start = 1'b0;
        step();
        total++;
        if ({busy, valid, sel, opcode, operand, len} !== {1'b0, 1'b1, 2'd0, 8'hAA, 16'h2355, 2'd3}) begin
            bad++; $display("FAIL len3_done got=%h exp=%h", {busy, valid, sel, opcode, operand, len}, {1'b0, 1'b1, 2'd0, 8'hAA, 16'h2355, 2'd3});
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
    endtask

    // Ends in DONE; test_hold_back_to_back continues from there.
    task automatic test_wrap();
        start = 1'b1; src = 2'd3;
        step();
        start = 1'b0;
        total++;
        if (sel !== 2'd3) begin
            bad++; $display("FAIL wrap_fop_sel got=%0d exp=%0d", sel, 3);
        end
        step();
        total++;
        if ({sel, opcode, len} !== {2'd0, 8'h78, 2'd2}) begin
            bad++; $display("FAIL wrap_fb1 got=%h exp=%h", {sel, opcode, len}, {2'd0, 8'h78, 2'd2});
        end
        step();
        total++;
        if ({busy, valid, opcode, operand, len} !== {1'b0, 1'b1, 8'h78, 16'h00AA, 2'd2}) begin
            bad++; $display("FAIL wrap_done got=%h exp=%h", {busy, valid, opcode, operand, len}, {1'b0, 1'b1, 8'h78, 16'h00AA, 2'd2});
        end
    endtask

    task automatic test_hold_back_to_back();
        ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            start = i[0];
            src   = 2'd1;
            step();
            total++;
            if ({busy, valid, sel, opcode, operand, len} !== {1'b0, 1'b1, 2'd0, 8'h78, 16'h00AA, 2'd2}) begin
                bad++; $display("FAIL hold_cycle%0d got=%h exp=%h", i, {busy, valid, sel, opcode, operand, len}, {1'b0, 1'b1, 2'd0, 8'h78, 16'h00AA, 2'd2});
            end
        end
        ack = 1'b1; start = 1'b1; src = 2'd2;
        step();
        ack = 1'b0; start = 1'b0;
        total++;
        if ({busy, valid, sel, operand} !== {1'b1, 1'b0, 2'd2, 16'h0000}) begin
            bad++; $display("FAIL b2b_fop got=%h exp=%h", {busy, valid, sel, operand}, {1'b1, 1'b0, 2'd2, 16'h0000});
        end
        step();
        total++;
        if ({busy, valid, opcode, operand, len} !== {1'b0, 1'b1, 8'h23, 16'h0000, 2'd1}) begin
            bad++; $display("FAIL b2b_done got=%h exp=%h", {busy, valid, opcode, operand, len}, {1'b0, 1'b1, 8'h23, 16'h0000, 2'd1});
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
    endtask

    task automatic test_async_reset();
        start = 1'b1; src = 2'd0;
        step();
        start = 1'b0;
        step();
        total++;
        if ({busy, sel, opcode} !== {1'b1, 2'd1, 8'hAA}) begin
            bad++; $display("FAIL arst_pre got=%h exp=%h", {busy, sel, opcode}, {1'b1, 2'd1, 8'hAA});
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({busy, valid, sel, opcode, operand, len} !== 30'h0) begin
            bad++; $display("FAIL arst_immediate got=%h exp=%h", {busy, valid, sel, opcode, operand, len}, 30'h0);
        end
        step();
        rst = 1'b0;
        start = 1'b1; src = 2'd1;
        step();
        start = 1'b0;
        total++;
        if ({busy, valid, sel} !== {1'b1, 1'b0, 2'd1}) begin
            bad++; $display("FAIL arst_restart got=%b exp=%b", {busy, valid, sel}, {1'b1, 1'b0, 2'd1});
        end
        step();
        step();
        total++;
        if ({busy, valid, opcode, operand, len} !== {1'b0, 1'b1, 8'h55, 16'h0023, 2'd2}) begin
            bad++; $display("FAIL arst_refetch got=%h exp=%h", {busy, valid, opcode, operand, len}, {1'b0, 1'b1, 8'h55, 16'h0023, 2'd2});
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_len1();
        test_len2();
        test_len3();
        test_wrap();
        test_hold_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
